toggle_period_meter: RTL and testbench
======================================

Name: toggle_period_meter

Overview:
Measures the period and high time of a slow, clock-like or toggling input (divided clocks, blink strobes, external square waves) in units of `clk` cycles. It is the receiving end of our divided-clock generation: it recovers the divide ratio from the waveform. It sits in the `clk` domain and feeds self-check logic, LED/UART debug readout and lock indicators.

Parameters:
- MAX_COUNT, default 27000000: longest measurable period in `clk` cycles. Reaching it without a rising edge is a timeout.
- SYNC_STAGES, default 2: number of synchronizer flops on `sig_in`. Minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  asynchronous signal to measure.
- period  output  W  last measured rising-to-rising period, in clk cycles. W = $clog2(MAX_COUNT+1).
- high_time  output  W  high time of that same period, in clk cycles.
- meas_valid  output  1  one-cycle pulse; `period` and `high_time` updated this cycle.
- locked  output  1  a valid measurement exists and no timeout has occurred since.
- timeout  output  1  sticky; no rising edge within MAX_COUNT cycles.

Behaviour:
- Reset (rst_n low, async): all synchronizer flops, the edge-history flop, the counter and the FSM clear to 0/IDLE. `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `timeout`=0. Release is synchronous to clk.
- Input path:
  - `sig_in` passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Edge events occur SYNC_STAGES+1 clk edges after `sig_in` changes.
- Counter `cnt`, W bits:
  - Cleared to 0 on a rise event; otherwise increments by 1 each cycle in MEASURE.
  - Never wraps: the timeout check fires before overflow.
- On a fall event in MEASURE: internal `hi_cap` <= cnt+1.
- FSM:
  - IDLE: a rise event clears `cnt` and moves to MEASURE; no measurement is produced. Fall events are ignored.
  - MEASURE, rise event: `period` <= cnt+1, `high_time` <= hi_cap, `meas_valid`=1 for one cycle, `locked`<=1, `timeout`<=0, `cnt`<=0. Stay in MEASURE.
  - MEASURE, no rise and cnt == MAX_COUNT-1: `timeout`<=1, `locked`<=0, go to IDLE. `period` and `high_time` hold their last values. No `meas_valid`.
- Arithmetic: for edges N cycles apart, period = N. A waveform with D cycles high and D cycles low yields period=2D, high_time=D.
- Boundary conditions:
  - Rise event on the same cycle cnt == MAX_COUNT-1: the edge wins. period=MAX_COUNT is reported as valid, with no timeout.
  - Period MAX_COUNT+1 or longer: timeout. The next rise is treated as a first edge.
  - `sig_in` high at reset release: the synchronizer goes 0->1 and this counts as a first rise (IDLE->MEASURE). No measurement results from it.
  - Glitches shorter than one clk may be missed. Pulses of at least 2 clk are always seen. A one-cycle high pulse gives high_time=1.
  - Reset mid-measurement aborts it; outputs return to reset values immediately.
- `meas_valid` never asserts on two consecutive cycles. The minimum measurable period is 2.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously. Release with sig_in=0 -> outputs stay 0, no `meas_valid`.
2. MAX_COUNT=64, square wave 10 high/10 low -> first `meas_valid` at the second rise event with period=20, high_time=10, locked=1. It then repeats every 20 cycles with identical values.
3. Duty change to 5 high/15 low without a gap -> next measurement reports period=20, high_time=5. Then 1 high/1 low -> period=2, high_time=1 every 2 cycles.
4. Timeout: hold sig_in low after a rise -> exactly 64 cycles after that rise event, timeout=1 and locked=0, with no `meas_valid`. Restart the 10/10 wave -> the first rise gives no output, the second gives period=20 with timeout=0 and locked=1.
5. Boundary: periods of 64 and 65 (MAX_COUNT=64) -> 64 is measured as valid with timeout=0; 65 gives timeout=1 and no valid.
6. Reset mid-measurement with sig_in held high, then release -> no spurious measurement. Two further rising edges 30 cycles apart -> period=30.

Source files
------------

// File: rtl/toggle_period_meter.sv
// Purpose : measure rising-to-rising period and high time of a slow async input, in clk cycles.
// Latency : edges seen SYNC_STAGES+1 clk edges after sig_in moves; result registered on the rise edge.
// Backpressure: none; meas_valid is a one-cycle pulse with no ready, consumers must sample it.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   sig_in       asynchronous input to be measured
//   period       last rising-to-rising period (clk cycles)
//   high_time    high time belonging to that same period
//   meas_valid   pulse: period/high_time were updated this cycle
//   locked       a valid measurement exists and no timeout since
//   timeout      sticky: no rising edge within MAX_COUNT cycles
module toggle_period_meter #(
    parameter int MAX_COUNT   = 27000000,
    parameter int SYNC_STAGES = 2,
    localparam int W          = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         meas_valid,
    output logic         locked,
    output logic         timeout
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [W-1:0] CNT_LAST = W'(MAX_COUNT - 1);
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   hist_q;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_s;
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~hist_q;
    assign fall   = ~sync_s & hist_q;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] cnt_q;
    logic [W-1:0] hi_cap_q;
    logic         at_limit;
    logic         do_meas;
    logic         do_timeout;

    assign at_limit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise arriving on the same cycle the counter hits its limit is a
    // legitimate period of exactly MAX_COUNT, so the rise is checked first.
    always_comb begin
        state_d    = state_q;
        do_meas    = 1'b0;
        do_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    do_meas = 1'b1;
                end else if (at_limit) begin
                    do_timeout = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cycle counter and high-time capture
    // cnt holds (cycles since the last rise) - 1, hence the +1 on capture.
    // The timeout check stops the count at MAX_COUNT-1, so it never wraps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= '0;
        end else if (do_timeout) begin
            cnt_q <= '0;
        end else if (state_q == MEASURE) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // hi_cap is cleared on each rise so a period without a fall can never
    // report a stale high time from an earlier period; the clear does not
    // disturb the value being handed to high_time on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cap_q <= '0;
        end else if (rise || do_timeout) begin
            hi_cap_q <= '0;
        end else if (fall && (state_q == MEASURE)) begin
            hi_cap_q <= cnt_q + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= do_meas;
            if (do_meas) begin
                period    <= cnt_q + CNT_ONE;
                high_time <= hi_cap_q;
                locked    <= 1'b1;
                timeout   <= 1'b0;
            end else if (do_timeout) begin
                locked    <= 1'b0;
                timeout   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toggle_period_meter.sv
module tb_toggle_period_meter;

    localparam int MAXC = 64;
    localparam int W    = $clog2(MAXC + 1);

    logic         clk;
    logic         rst_n;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         locked;
    logic         timeout;

    toggle_period_meter #(
        .MAX_COUNT  (MAXC),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int per;
        int hi;
        int lk;
        int to;
    } ev_t;

    ev_t evq[$];
    int  cyc      = 0;
    int  b2b      = 0;
    int  to_rise  = -1;
    logic prev_mv = 1'b0;
    logic prev_to = 1'b0;
    int  total    = 0;
    int  bad      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every measurement pulse away from the active edge.
    always @(negedge clk) begin
        if (meas_valid) begin
            evq.push_back('{cyc: cyc, per: int'(period), hi: int'(high_time),
                            lk: int'(locked), to: int'(timeout)});
            if (prev_mv) b2b <= b2b + 1;
        end
        prev_mv <= meas_valid;
        if (timeout && !prev_to) to_rise <= cyc;
        prev_to <= timeout;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold sig_in at v for n clk cycles; returns just after a rising edge.
    task automatic drive(input logic v, input int n);
        sig_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_ev(input string ph, input int idx, input int base,
                          input int off, input int per, input int hi);
        if (idx >= evq.size()) begin
            chk($sformatf("%s_ev%0d_present", ph, idx), evq.size(), idx + 1);
        end else begin
            chk($sformatf("%s_ev%0d_cyc", ph, idx), evq[idx].cyc - base, off);
            chk($sformatf("%s_ev%0d_per", ph, idx), evq[idx].per, per);
            chk($sformatf("%s_ev%0d_hi", ph, idx), evq[idx].hi, hi);
            chk($sformatf("%s_ev%0d_lk", ph, idx), evq[idx].lk, 1);
            chk($sformatf("%s_ev%0d_to", ph, idx), evq[idx].to, 0);
        end
    endtask

    // Hand-computed expectations: offset = rise drive cycle + 3 (2 sync + history).
    int p2_off[13] = '{23, 43, 63, 83, 103, 123, 143, 163, 165, 167, 169, 171, 173};
    int p2_per[13] = '{20, 20, 20, 20, 20, 20, 20, 20, 2, 2, 2, 2, 2};
    int p2_hi [13] = '{10, 10, 10, 10, 10, 5, 5, 5, 1, 1, 1, 1, 1};
    int p4_off[5]  = '{23, 43, 107, 192, 212};
    int p4_per[5]  = '{20, 20, 64, 20, 20};

    int c0;
    int c1;
    int c2;

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", int'(period), 0);
        chk("rst_high", int'(high_time), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        drive(1'b0, 10);
        chk("idle_nevents", evq.size(), 0);
        chk("idle_locked", int'(locked), 0);
        chk("idle_timeout", int'(timeout), 0);
        chk("idle_period", int'(period), 0);

        // 10/10 x5, 5/15 x3, 1/1 x6, then held low into a timeout.
        c0 = cyc;
        repeat (5) begin drive(1'b1, 10); drive(1'b0, 10); end
        repeat (3) begin drive(1'b1, 5);  drive(1'b0, 15); end
        repeat (6) begin drive(1'b1, 1);  drive(1'b0, 1);  end
        drive(1'b0, 80);
        chk("p2_nevents", evq.size(), 13);
        for (int i = 0; i < 13; i++) chk_ev("p2", i, c0, p2_off[i], p2_per[i], p2_hi[i]);
        chk("p2_to_cyc", to_rise - c0, 170 + 67);
        chk("p2_timeout", int'(timeout), 1);
        chk("p2_locked", int'(locked), 0);
        chk("p2_period_hold", int'(period), 2);
        chk("p2_high_hold", int'(high_time), 1);

        // Restart after timeout, then periods of 64 (valid) and 65 (timeout).
        evq.delete();
        c1 = cyc;
        drive(1'b1, 10); drive(1'b0, 10);
        chk("p4_first_rise_noev", evq.size(), 0);
        chk("p4_first_rise_to", int'(timeout), 1);
        drive(1'b1, 10); drive(1'b0, 10);
        drive(1'b1, 10); drive(1'b0, 54);
        drive(1'b1, 10); drive(1'b0, 55);
        drive(1'b1, 10); drive(1'b0, 10);
        drive(1'b1, 10); drive(1'b0, 10);
        drive(1'b1, 20);
        chk("p4_nevents", evq.size(), 5);
        for (int i = 0; i < 5; i++) chk_ev("p4", i, c1, p4_off[i], p4_per[i], 10);
        chk("p5_to_cyc", to_rise - c1, 104 + 67);
        chk("p5_locked", int'(locked), 1);
        chk("p5_period", int'(period), 20);

        // Asynchronous reset mid-cycle with sig_in high.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_high", int'(high_time), 0);
        chk("arst_valid", int'(meas_valid), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_timeout", int'(timeout), 0);
        repeat (4) @(posedge clk);
        #1;
        evq.delete();
        rst_n = 1'b1;
        c2 = cyc;
        drive(1'b1, 80);
        chk("p6_nospurious", evq.size(), 0);
        chk("p6_timeout", int'(timeout), 1);
        chk("p6_locked", int'(locked), 0);
        drive(1'b0, 15);
        drive(1'b1, 15);
        drive(1'b0, 15);
        drive(1'b1, 20);
        chk("p6_nevents", evq.size(), 1);
        chk_ev("p6", 0, c2, 128, 30, 15);

        chk("no_back_to_back", b2b, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
